// File: rtl/spi_accel_target.sv
// SPI mode-0 target modelling a 3-axis accelerometer.
// Oversamples SCLK/CS/MOSI in the system clock domain and decodes frames:
//   0x0A addr data... : register write
//   0x0B addr dummy...: register read (data returned on MISO)
// Holds an 8-bit register file and captures axis samples into 0x08..0x0A.
// Ports:
//   i_clk_100MHZ, i_rst_n             : system clock, async active-low reset
//   i_sclk, i_mosi, i_cs, o_miso       : SPI pins (CS active-low)
//   i_sample_valid, i_{x,y,z}_sample   : axis sample strobe and data
//   o_reg_wr_valid/addr/data           : one-cycle pulse per committed write
//   o_meas_en                          : POWER_CTL[1:0] == 2'b10
//   o_frame_err                        : one-cycle pulse on a malformed frame
// Optional feature: define ACCEL_TGT_AUTOINC_EN to auto-increment the address
// after each data byte in burst frames; otherwise the address stays fixed.
module spi_accel_target #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hAD
) (
  input  logic              i_clk_100MHZ,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs,
  output logic              o_miso,
  input  logic              i_sample_valid,
  input  logic [7:0]        i_x_sample,
  input  logic [7:0]        i_y_sample,
  input  logic [7:0]        i_z_sample,
  output logic              o_reg_wr_valid,
  output logic [ADDR_W-1:0] o_reg_wr_addr,
  output logic [7:0]        o_reg_wr_data,
  output logic              o_meas_en,
  output logic              o_frame_err
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] XAddr        = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] YAddr        = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ZAddr        = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] StatusAddr   = ADDR_W'(11);
  localparam logic [ADDR_W-1:0] SoftRstAddr  = ADDR_W'(31);
  localparam logic [ADDR_W-1:0] PowerCtlAddr = ADDR_W'(45);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDataWr, StDataRd, StIgnore} state_e;

  function automatic logic [7:0] reset_val(input logic [ADDR_W-1:0] a);
    unique case (a)
      ADDR_W'(0): reset_val = DEVID;
      ADDR_W'(1): reset_val = 8'h1D;
      ADDR_W'(2): reset_val = 8'hF2;
      default:    reset_val = 8'h00;
    endcase
  endfunction

  function automatic logic is_ro(input logic [ADDR_W-1:0] a);
    is_ro = (a <= ADDR_W'(2)) || ((a >= XAddr) && (a <= StatusAddr));
  endfunction

  // Synchronizers plus one extra stage for edge detection.
  logic [SYNC_STAGES-1:0] sclk_sync_d, sclk_sync_q, cs_sync_d, cs_sync_q, mosi_sync_d, mosi_sync_q;
  logic sclk_prev_d, sclk_prev_q, cs_prev_d, cs_prev_q;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // CS chain resets low: a CS already low when reset releases never looks like a
  // falling edge, so a frame interrupted by reset is ignored until the next one.
  always_ff @(posedge i_clk_100MHZ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  state_e              state_d, state_q;
  logic [2:0]          bit_cnt_d, bit_cnt_q;
  logic [6:0]          rx_d, rx_q;
  logic [7:0]          tx_d, tx_q;
  logic [ADDR_W-1:0]   addr_d, addr_q, addr_nxt, rx_addr;
  logic                is_rd_d, is_rd_q, miso_d, miso_q;
  logic                wr_valid_d, wr_valid_q, frame_err_d, frame_err_q;
  logic [ADDR_W-1:0]   wr_addr_d, wr_addr_q;
  logic [7:0]          wr_data_d, wr_data_q;
  logic                clr_status_d, clr_status_q, soft_rst_d, soft_rst_q;
  logic                pend_d, pend_q, capture;
  logic [7:0]          pend_x_d, pend_x_q, pend_y_d, pend_y_q, pend_z_d, pend_z_q;
  logic [7:0]          regs_d [NumRegs];
  logic [7:0]          regs_q [NumRegs];
  logic [7:0]          rx_byte;
  logic                byte_done;

  assign rx_byte   = {rx_q, mosi_s};
  assign rx_addr   = rx_byte[ADDR_W-1:0];
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);
  assign o_meas_en = (regs_q[PowerCtlAddr][1:0] == 2'b10);
  assign capture   = o_meas_en && i_sample_valid;

`ifdef ACCEL_TGT_AUTOINC_EN
  assign addr_nxt = addr_q + ADDR_W'(1);
`else
  assign addr_nxt = addr_q;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    is_rd_d      = is_rd_q;
    miso_d       = miso_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_err_d  = 1'b0;
    clr_status_d = clr_status_q;
    soft_rst_d   = soft_rst_q;
    pend_d       = pend_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_z_d     = pend_z_q;
    regs_d       = regs_q;

    if (cs_rise) begin
      state_d   = StIdle;
      miso_d    = 1'b0;
      bit_cnt_d = 3'd0;
      if (state_q != StIdle && bit_cnt_q != 3'd0) frame_err_d = 1'b1;
    end else if (cs_fall && state_q == StIdle) begin
      state_d   = StCmd;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (state_q != StIdle) begin
      if (sclk_rise) begin
        rx_d      = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall && state_q == StDataRd) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
      if (byte_done) begin
        unique case (state_q)
          StCmd: begin
            if (rx_byte == 8'h0A || rx_byte == 8'h0B) begin
              is_rd_d = (rx_byte == 8'h0B);
              state_d = StAddr;
            end else begin
              state_d     = StIgnore;
              frame_err_d = 1'b1;
            end
          end
          StAddr: begin
            addr_d = rx_addr;
            if (is_rd_q) begin
              tx_d    = regs_q[rx_addr];
              state_d = StDataRd;
              if (rx_addr == XAddr) clr_status_d = 1'b1;
            end else begin
              state_d = StDataWr;
            end
          end
          StDataWr: begin
            if (!is_ro(addr_q)) begin
              regs_d[addr_q] = rx_byte;
              wr_valid_d     = 1'b1;
              wr_addr_d      = addr_q;
              wr_data_d      = rx_byte;
              if (addr_q == SoftRstAddr && rx_byte == 8'h52) soft_rst_d = 1'b1;
            end
            addr_d = addr_nxt;
          end
          StDataRd: begin
            addr_d = addr_nxt;
            tx_d   = regs_q[addr_nxt];
            if (addr_nxt == XAddr) clr_status_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Sample path: buffer while CS is low so a burst read sees one coherent set.
    if (capture && !cs_s) begin
      pend_d   = 1'b1;
      pend_x_d = i_x_sample;
      pend_y_d = i_y_sample;
      pend_z_d = i_z_sample;
    end

    if (cs_rise) begin
      if (soft_rst_q) begin
        for (int unsigned i = 0; i < NumRegs; i++) regs_d[i] = reset_val(ADDR_W'(i));
      end else begin
        if (clr_status_q) regs_d[StatusAddr][0] = 1'b0;
        if (pend_q) begin
          regs_d[XAddr]         = pend_x_q;
          regs_d[YAddr]         = pend_y_q;
          regs_d[ZAddr]         = pend_z_q;
          regs_d[StatusAddr][0] = 1'b1;
        end
      end
      pend_d       = 1'b0;
      clr_status_d = 1'b0;
      soft_rst_d   = 1'b0;
    end

    if (capture && cs_s) begin
      regs_d[XAddr]         = i_x_sample;
      regs_d[YAddr]         = i_y_sample;
      regs_d[ZAddr]         = i_z_sample;
      regs_d[StatusAddr][0] = 1'b1;
    end
  end

  always_ff @(posedge i_clk_100MHZ or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= 3'd0;
      rx_q         <= 7'd0;
      tx_q         <= 8'd0;
      addr_q       <= '0;
      is_rd_q      <= 1'b0;
      miso_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'd0;
      frame_err_q  <= 1'b0;
      clr_status_q <= 1'b0;
      soft_rst_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_x_q     <= 8'd0;
      pend_y_q     <= 8'd0;
      pend_z_q     <= 8'd0;
      for (int unsigned i = 0; i < NumRegs; i++) regs_q[i] <= reset_val(ADDR_W'(i));
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      is_rd_q      <= is_rd_d;
      miso_q       <= miso_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_err_q  <= frame_err_d;
      clr_status_q <= clr_status_d;
      soft_rst_q   <= soft_rst_d;
      pend_q       <= pend_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_z_q     <= pend_z_d;
      regs_q       <= regs_d;
    end
  end

  assign o_miso         = miso_q;
  assign o_reg_wr_valid = wr_valid_q;
  assign o_reg_wr_addr  = wr_addr_q;
  assign o_reg_wr_data  = wr_data_q;
  assign o_frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_accel_target.sv
// Bench for spi_accel_target: drives SPI frames (SCLK half period 16 clocks),
// predicts MISO bytes, write pulses, frame errors and POWER_CTL state from a
// register-file model, and also pins key results to literal values.
module tb_spi_accel_target;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, cs = 1'b1, sv = 1'b0;
  logic [7:0] xs = 8'h0, ys = 8'h0, zs = 8'h0;
  logic       miso, wr_valid, meas_en, ferr;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  spi_accel_target dut (
    .i_clk_100MHZ  (clk),
    .i_rst_n       (rst_n),
    .i_sclk        (sclk),
    .i_mosi        (mosi),
    .i_cs          (cs),
    .o_miso        (miso),
    .i_sample_valid(sv),
    .i_x_sample    (xs),
    .i_y_sample    (ys),
    .i_z_sample    (zs),
    .o_reg_wr_valid(wr_valid),
    .o_reg_wr_addr (wr_addr),
    .o_reg_wr_data (wr_data),
    .o_meas_en     (meas_en),
    .o_frame_err   (ferr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- model ----------------
  logic [7:0]  m_regs [64];
  bit          m_pend, m_clr, m_soft;
  logic [7:0]  m_px, m_py, m_pz;
  logic [13:0] exp_wr[$];
  logic [7:0]  exp_miso[$];
  logic [7:0]  got_miso[$];
  int          exp_ferr, got_ferr;
  bit          idle_chk = 1'b0;

  function automatic bit m_ro(input int a);
    return (a <= 2) || (a >= 8 && a <= 11);
  endfunction

  function automatic int m_inc(input int a);
`ifdef ACCEL_TGT_AUTOINC_EN
    return (a + 1) % 64;
`else
    return a;
`endif
  endfunction

  function automatic bit m_meas_en();
    return m_regs[45][1:0] == 2'b10;
  endfunction

  task automatic m_reset_regs();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_regs[0] = 8'hAD;
    m_regs[1] = 8'h1D;
    m_regs[2] = 8'hF2;
  endtask

  task automatic m_reset();
    m_reset_regs();
    m_pend = 0;
    m_clr  = 0;
    m_soft = 0;
  endtask

  task automatic m_sample(input logic [7:0] x, y, z, input bit cs_low);
    if (m_meas_en()) begin
      if (cs_low) begin
        m_pend = 1; m_px = x; m_py = y; m_pz = z;
      end else begin
        m_regs[8] = x; m_regs[9] = y; m_regs[10] = z; m_regs[11][0] = 1'b1;
      end
    end
  endtask

  task automatic m_cs_rise();
    if (m_soft) begin
      m_reset_regs();
    end else begin
      if (m_clr) m_regs[11][0] = 1'b0;
      if (m_pend) begin
        m_regs[8] = m_px; m_regs[9] = m_py; m_regs[10] = m_pz; m_regs[11][0] = 1'b1;
      end
    end
    m_pend = 0; m_clr = 0; m_soft = 0;
  endtask

  task automatic model_frame(input logic [7:0] b[$], input int part);
    int a;
    bit rd;
    exp_miso.delete();
    foreach (b[i]) exp_miso.push_back(8'h00);
    exp_ferr = (part > 0) ? 1 : 0;
    if (b.size() >= 1) begin
      if (b[0] != 8'h0A && b[0] != 8'h0B) begin
        exp_ferr++;
      end else if (b.size() >= 2) begin
        rd = (b[0] == 8'h0B);
        a  = int'(b[1]) % 64;
        if (rd && a == 8) m_clr = 1;
        for (int i = 2; i < b.size(); i++) begin
          if (rd) begin
            exp_miso[i] = m_regs[a];
            a = m_inc(a);
            if (a == 8) m_clr = 1;
          end else begin
            if (!m_ro(a)) begin
              m_regs[a] = b[i];
              exp_wr.push_back({6'(a), b[i]});
              if (a == 31 && b[i] == 8'h52) m_soft = 1;
            end
            a = m_inc(a);
          end
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid) begin
        if (exp_wr.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL wr_pulse: got unexpected write addr 0x%0h data 0x%0h, expected none",
                   wr_addr, wr_data);
        end else begin
          check("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
        end
      end
      if (ferr) got_ferr++;
      if (idle_chk) begin
        check("idle_miso", miso, 1'b0);
        check("meas_en", meas_en, m_meas_en());
      end
    end
  end

  // ---------------- SPI driver ----------------
  task automatic send_byte(input logic [7:0] v, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = v[7-i];
      tick(16);
      r = {r[6:0], miso};
      sclk = 1'b1;
      tick(16);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b[$], input logic [7:0] pb, input int part,
                       input int strobe_at, input logic [7:0] sx, sy, sz);
    logic [7:0] r;
    model_frame(b, part);
    got_ferr = 0;
    got_miso.delete();
    idle_chk = 1'b0;
    cs = 1'b0;
    tick(16);
    foreach (b[i]) begin
      if (strobe_at == i) begin
        xs = sx; ys = sy; zs = sz; sv = 1'b1;
        tick(1);
        sv = 1'b0;
        m_sample(sx, sy, sz, 1'b1);
      end
      send_byte(b[i], 8, r);
      got_miso.push_back(r);
    end
    if (part > 0) send_byte(pb, part, r);
    tick(16);
    cs = 1'b1;
    tick(8);
    m_cs_rise();
    tick(8);
    idle_chk = 1'b1;
    foreach (got_miso[i]) check($sformatf("miso_byte[%0d]", i), got_miso[i], exp_miso[i]);
    check("frame_err_count", got_ferr, exp_ferr);
    check("missing_writes", exp_wr.size(), 0);
  endtask

  task automatic idle_sample(input logic [7:0] x, y, z);
    xs = x; ys = y; zs = z; sv = 1'b1;
    tick(1);
    sv = 1'b0;
    m_sample(x, y, z, 1'b0);
    tick(4);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_wr_valid"}, wr_valid, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_meas_en"}, meas_en, 0);
    check({tag, "_frame_err"}, ferr, 0);
    check({tag, "_miso"}, miso, 0);
  endtask

  initial begin
    logic [7:0] r;
    m_reset();
    tick(5);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    tick(10);
    chk_reset_outputs("after_reset");
    idle_chk = 1'b1;

    // Read DEVID at reset.
    frame('{8'h0B, 8'h00, 8'hFF}, 8'h0, 0, -1, 0, 0, 0);
    check("devid_literal", got_miso[2], 8'hAD);

    // Write POWER_CTL, read it back.
    frame('{8'h0A, 8'h2D, 8'h02}, 8'h0, 0, -1, 0, 0, 0);
    check("meas_en_literal", meas_en, 1'b1);
    frame('{8'h0B, 8'h2D, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("powerctl_literal", got_miso[2], 8'h02);

    // Read-only address is not written.
    frame('{8'h0A, 8'h01, 8'h77}, 8'h0, 0, -1, 0, 0, 0);
    frame('{8'h0B, 8'h01, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("ro_literal", got_miso[2], 8'h1D);

    // Burst read of sample registers.
    idle_sample(8'h11, 8'h22, 8'h33);
    frame('{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
`ifdef ACCEL_TGT_AUTOINC_EN
    check("burst_lit_x", got_miso[2], 8'h11);
    check("burst_lit_y", got_miso[3], 8'h22);
    check("burst_lit_z", got_miso[4], 8'h33);
    check("burst_lit_status", got_miso[5], 8'h01);
`else
    check("fixed_lit_0", got_miso[2], 8'h11);
    check("fixed_lit_3", got_miso[5], 8'h11);
`endif
    frame('{8'h0B, 8'h0B, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("status_cleared_literal", got_miso[2], 8'h00);

    // Coherency: sample strobed mid-burst lands only after CS rises.
    frame('{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00}, 8'h0, 0, 3, 8'h44, 8'h55, 8'h66);
    check("coherent_old_x_literal", got_miso[2], 8'h11);
    frame('{8'h0B, 8'h0B, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("status_set_by_pending_literal", got_miso[2], 8'h01);
    frame('{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("coherent_new_x_literal", got_miso[2], 8'h44);
`ifdef ACCEL_TGT_AUTOINC_EN
    check("coherent_new_z_literal", got_miso[4], 8'h66);
`endif

    // Bad command.
    frame('{8'h0C, 8'h00, 8'h55}, 8'h0, 0, -1, 0, 0, 0);
    check("badcmd_err_literal", got_ferr, 1);
    check("badcmd_miso_literal", got_miso[2], 8'h00);

    // Partial data byte: no write, error pulse.
    frame('{8'h0A, 8'h2D}, 8'h07, 5, -1, 0, 0, 0);
    check("partial_err_literal", got_ferr, 1);
    frame('{8'h0B, 8'h2D, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("partial_unchanged_literal", got_miso[2], 8'h02);

    // Soft reset.
    frame('{8'h0A, 8'h1F, 8'h52}, 8'h0, 0, -1, 0, 0, 0);
    check("softrst_meas_en_literal", meas_en, 1'b0);
    frame('{8'h0B, 8'h2D, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("softrst_powerctl_literal", got_miso[2], 8'h00);

    // Hard reset in the middle of a write.
    frame('{8'h0A, 8'h2D, 8'h02}, 8'h0, 0, -1, 0, 0, 0);
    idle_chk = 1'b0;
    got_ferr = 0;
    cs = 1'b0;
    tick(16);
    send_byte(8'h0A, 8, r);
    send_byte(8'h2D, 8, r);
    send_byte(8'h02, 3, r);
    rst_n = 1'b0;
    m_reset();
    tick(3);
    chk_reset_outputs("mid_reset");
    rst_n = 1'b1;
    tick(4);
    send_byte(8'h00, 5, r);
    tick(16);
    cs = 1'b1;
    tick(16);
    idle_chk = 1'b1;
    check("midreset_no_err", got_ferr, 0);
    frame('{8'h0B, 8'h2D, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("midreset_powerctl_literal", got_miso[2], 8'h00);
    frame('{8'h0A, 8'h2D, 8'h02}, 8'h0, 0, -1, 0, 0, 0);
    frame('{8'h0B, 8'h2D, 8'h00}, 8'h0, 0, -1, 0, 0, 0);
    check("clean_after_reset_literal", got_miso[2], 8'h02);

    idle_chk = 1'b0;
    tick(4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_accel_target.md
Name: spi_accel_target

Overview:
SPI mode-0 target that models the 3-axis accelerometer on the board side of the SPI link. It decodes write-register (0x0A) and read-register (0x0B) frames from our SPI controller, maintains an 8-bit register file, and serves axis samples from the sample ports. It is used as the synthesizable peripheral model in controller simulation and loopback FPGA builds. It oversamples SCLK, CS and MOSI in the system clock domain.

Parameters:
ADDR_W, 6, register address width; the register file has 2**ADDR_W entries.
SYNC_STAGES, 2, synchronizer depth on i_sclk, i_cs and i_mosi; minimum 2.
DEVID, 8'hAD, read-only value at address 0x00.

Ports:
i_clk_100MHZ  in  1  system clock
i_rst_n  in  1  reset, asynchronous assert, active-low
i_sclk  in  1  SPI clock from the controller; idle low
i_mosi  in  1  controller-to-target data
i_cs  in  1  chip select, active-low
o_miso  out  1  target-to-controller data; 0 while i_cs is high
i_sample_valid  in  1  one-cycle strobe that qualifies the sample ports
i_x_sample / i_y_sample / i_z_sample  in  8 each  axis data
o_reg_wr_valid  out  1  one-cycle pulse per committed write
o_reg_wr_addr  out  ADDR_W  address of the committed write
o_reg_wr_data  out  8  data of the committed write
o_meas_en  out  1  POWER_CTL (0x2D) bits[1:0]==2'b10
o_frame_err  out  1  one-cycle pulse on a malformed frame

Behaviour:
- Clocking and reset: one clock, i_clk_100MHZ. Reset is asynchronous, active-low (i_rst_n).
- Reset values: all outputs 0; FSM in IDLE; register file 0 except 0x00=DEVID, 0x01=8'h1D, 0x02=8'hF2.
- Sampling:
  - Inputs pass through SYNC_STAGES flops.
  - Edges are detected from the last two synchronized SCLK samples.
  - SCLK high and low phases must each be at least 4 clocks.
- Mode-0 timing:
  - MOSI is sampled on a detected SCLK rising edge. Bits arrive MSB first.
  - o_miso updates on a detected SCLK falling edge.
  - Latency is SYNC_STAGES+1 clocks after the pin edge.
- FSM states: IDLE, CMD, ADDR, DATA_WR, DATA_RD, IGNORE. A 3-bit counter counts rising edges within the current byte.
  - IDLE: a synchronized CS falling edge goes to CMD and clears the bit counter.
  - CMD: on the 8th rising edge, command 0x0A or 0x0B goes to ADDR. Any other command goes to IGNORE and pulses o_frame_err.
  - ADDR: on the 8th rising edge, latch addr. For a read command, also load tx_shift with reg[addr] and go to DATA_RD; otherwise go to DATA_WR.
  - DATA_WR: on the 8th rising edge, commit the byte unless addr is a read-only address (0x00-0x02, 0x08-0x0B). Pulse o_reg_wr_valid/addr/data for one clock, then addr+1.
  - DATA_RD: each falling edge drives o_miso=tx_shift[7] and shifts tx_shift left. On the 8th rising edge, addr+1 and reload tx_shift.
  - IGNORE: o_miso=0 until CS rises.
- Address wrap: addr increments modulo 2**ADDR_W.
- CS rising edge (from any state) returns to IDLE and forces o_miso=0.
  - A bit counter that is not 0 at that point means a partial byte. The partial byte is discarded with no write, and o_frame_err pulses.
  - CS rising in CMD or ADDR with counter 0 is treated as an empty frame: no error.
- Sample path:
  - When o_meas_en=1 and i_sample_valid=1, x/y/z are captured into 0x08/0x09/0x0A and STATUS (0x0B) bit0 is set.
  - While CS is low, captures go to a pending buffer. The newest sample wins. Pending data is applied on the CS rising edge, so a burst read is always coherent.
  - A read that loads 0x08 clears STATUS bit0 at CS rise. A capture applied at that same CS rise takes priority and leaves bit0 set.
- Soft reset: a write of 8'h52 to 0x1F restores register-file reset values at CS rise. FSM and output state are not affected.
- Reset mid-frame: all state clears immediately. The frame is ignored until the next CS falling edge.

Optional Feature:
ACCEL_TGT_AUTOINC_EN:
- Defined: burst frames auto-increment addr after each data byte, as described above.
- Undefined: addr stays fixed for the whole frame. Repeated reads return the same register. Repeated writes overwrite the same register, with one o_reg_wr_valid pulse per byte.

Test Plan:
- Read at reset: 0x0B,0x00,dummy, SCLK 3.125MHz (16-clock half period) -> MISO byte 0xAD.
- Write: 0x0A,0x2D,0x02 -> one o_reg_wr_valid with addr 0x2D, data 0x02; o_meas_en=1; read-back returns 0x02.
- Burst read with AUTOINC_EN: measurement on, sample x=0x11 y=0x22 z=0x33, then 0x0B,0x08 plus 4 bytes -> 0x11,0x22,0x33,0x01; STATUS bit0=0 after CS rises.
- Coherency: sample 0x44/0x55/0x66 strobed mid-burst of 0x08-0x0A -> old bytes returned; the next frame returns 0x44,0x55,0x66.
- Errors: command 0x0C -> o_frame_err pulse, MISO 0 for the whole frame. CS raised after 5 bits of a write data byte -> o_frame_err pulse, no write pulse, register unchanged.
- Robustness: i_rst_n low mid-write -> outputs 0, 0x2D=0x00; a following clean frame works. Write to 0x01 -> ignored, reads 0x1D.
